// File: rtl/jgate_bank.sv
// ---------------------------------------------------------------------------
// jgate_bank
//   Bit-parallel bank of the basic logic primitives (AND, OR, NOT) applied
//   across two WIDTH-bit operand buses. Each function is available as a
//   zero-delay combinational output and as a registered copy loaded under
//   a plain load enable.
//
// Ports
//   clk      : single clock, registers update on its rising edge
//   reset    : asynchronous active-low reset, clears all registered outputs
//   en       : load enable for the registered outputs
//   a        : operand A (also the sole inverter input)
//   b        : operand B
//   and_o    : combinational a & b
//   or_o     : combinational a | b
//   not_o    : combinational ~a
//   and_q    : registered AND result
//   or_q     : registered OR result
//   not_q    : registered NOT result
//   valid_q  : 1 once at least one load has happened since reset
// ---------------------------------------------------------------------------
module jgate_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] and_o,
  output logic [WIDTH-1:0] or_o,
  output logic [WIDTH-1:0] not_o,
  output logic [WIDTH-1:0] and_q,
  output logic [WIDTH-1:0] or_q,
  output logic [WIDTH-1:0] not_q,
  output logic             valid_q
);

  // NOTE: continuous assigns give pure gates with no storage; an
  // always_comb with a missing branch here would infer a latch and break
  // the primitives' use inside feedback structures.
  assign and_o = a & b;
  assign or_o  = a | b;
  assign not_o = ~a;

  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values of the combinational results.
  // NOTE: reset is in the sensitivity list so the clear is immediate and
  // also wins over a clock edge arriving in the same timestep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      and_q   <= '0;
      or_q    <= '0;
      not_q   <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      and_q   <= and_o;
      or_q    <= or_o;
      not_q   <= not_o;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jgate_bank.sv
// ---------------------------------------------------------------------------
// tb_jgate_bank
//   Self-checking bench for jgate_bank: a WIDTH=1 truth-table instance and a
//   WIDTH=8 instance driven by directed sequences and random stimulus,
//   compared against a bit-level arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_jgate_bank;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [W-1:0] a, b;
  logic [W-1:0] and_o, or_o, not_o, and_q, or_q, not_q;
  logic         valid_q;

  logic a1, b1, en1;
  logic and1_o, or1_o, not1_o, and1_q, or1_q, not1_q, valid1_q;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jgate_bank #(.WIDTH(W)) u_dut (
    .clk(clk), .reset(reset), .en(en), .a(a), .b(b),
    .and_o(and_o), .or_o(or_o), .not_o(not_o),
    .and_q(and_q), .or_q(or_q), .not_q(not_q), .valid_q(valid_q)
  );

  jgate_bank #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .en(en1), .a(a1), .b(b1),
    .and_o(and1_o), .or_o(or1_o), .not_o(not1_o),
    .and_q(and1_q), .or_q(or1_q), .not_q(not1_q), .valid_q(valid1_q)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: per-bit gates computed with counting arithmetic.
  typedef struct {
    logic [W-1:0] and_v;
    logic [W-1:0] or_v;
    logic [W-1:0] not_v;
  } gate_res_t;

  function automatic gate_res_t ref_gates(input logic [W-1:0] x, input logic [W-1:0] y);
    gate_res_t r;
    for (int i = 0; i < W; i++) begin
      int ones;
      ones = int'(x[i]) + int'(y[i]);
      r.and_v[i] = (ones == 2);
      r.or_v[i]  = (ones >= 1);
      r.not_v[i] = (x[i] == 1'b0);
    end
    return r;
  endfunction

  gate_res_t m_q;
  logic      m_valid;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_q(input string tag);
    check({tag, " and_q"},   and_q,   m_q.and_v);
    check({tag, " or_q"},    or_q,    m_q.or_v);
    check({tag, " not_q"},   not_q,   m_q.not_v);
    check({tag, " valid_q"}, valid_q, m_valid);
  endtask

  typedef struct {
    logic a, b, e_and, e_or, e_not;
  } tt_vec_t;

  tt_vec_t tt [4];

  initial begin
    gate_res_t exp_c;
    time t0;

    tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tt[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tt[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    reset = 1'b0; en = 1'b0; a = '0; b = '0;
    a1 = 1'b0; b1 = 1'b0; en1 = 1'b0;
    m_q = '{default: '0}; m_valid = 1'b0;
    tick(); tick();
    check_q("reset");

    // Truth table on the single-bit instance.
    for (int i = 0; i < 4; i++) begin
      a1 = tt[i].a; b1 = tt[i].b;
      #1;
      check($sformatf("tt%0d and", i), and1_o, tt[i].e_and);
      check($sformatf("tt%0d or", i),  or1_o,  tt[i].e_or);
      check($sformatf("tt%0d not", i), not1_o, tt[i].e_not);
    end

    // Bus load.
    reset = 1'b1;
    a = 8'hF0; b = 8'h3C; en = 1'b1;
    tick();
    check("bus and_q", and_q, 8'h30);
    check("bus or_q",  or_q,  8'hFC);
    check("bus not_q", not_q, 8'h0F);
    check("bus valid", valid_q, 1'b1);

    // Enable hold.
    a = 8'hAA; b = 8'h55; en = 1'b1;
    tick();
    en = 1'b0; a = 8'h00; b = 8'hFF;
    #1;
    check("hold or_o", or_o, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold%0d and_q", i), and_q, 8'h00);
      check($sformatf("hold%0d or_q", i),  or_q,  8'hFF);
      check($sformatf("hold%0d not_q", i), not_q, 8'h55);
    end

    // Async reset between edges.
    #2;
    reset = 1'b0;
    #1;
    check("arst and_q", and_q, 8'h00);
    check("arst or_q",  or_q,  8'h00);
    check("arst not_q", not_q, 8'h00);
    check("arst valid", valid_q, 1'b0);
    check("arst or_o",  or_o,  8'hFF);
    check("arst not_o", not_o, 8'hFF);
    // Registers stay clear while reset is held, even with en=1.
    en = 1'b1; a = 8'h5A; b = 8'hC3;
    tick();
    check("rhold and_q", and_q, 8'h00);
    check("rhold valid", valid_q, 1'b0);

    // Reset release with en low, then an enabled load.
    en = 1'b0;
    #2; reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("rel%0d or_q", i), or_q, 8'h00);
      check($sformatf("rel%0d valid", i), valid_q, 1'b0);
    end
    en = 1'b1; a = 8'h81; b = 8'h01;
    tick();
    check("rel and_q", and_q, 8'h01);
    check("rel or_q",  or_q,  8'h81);
    check("rel not_q", not_q, 8'h7E);
    check("rel valid", valid_q, 1'b1);

    // Zero-delay response of the combinational path.
    en = 1'b0; b = 8'hFF; a = 8'h00;
    #1;
    t0 = $time;
    a = 8'h01;
    fork
      begin @(and_o); end
      begin #1; end
    join_any
    disable fork;
    check("zd time", 64'($time), 64'(t0));
    check("zd and_o0 rise", and_o[0], 1'b1);
    t0 = $time;
    a = 8'h00;
    fork
      begin @(and_o); end
      begin #1; end
    join_any
    disable fork;
    check("zd time fall", 64'($time), 64'(t0));
    check("zd and_o0 fall", and_o[0], 1'b0);

    // Random stimulus against the reference model.
    m_q = ref_gates(8'h81, 8'h01); m_valid = 1'b1;
    #1;
    for (int i = 0; i < 200; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      en = 1'($urandom_range(0, 1));
      #1;
      exp_c = ref_gates(a, b);
      check("rnd and_o", and_o, exp_c.and_v);
      check("rnd or_o",  or_o,  exp_c.or_v);
      check("rnd not_o", not_o, exp_c.not_v);
      tick();
      if (en) begin
        m_q = exp_c;
        m_valid = 1'b1;
      end
      check_q("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jgate_bank.md
# jgate_bank

Bit-parallel bank of the codebase's basic logic primitives: 2-input AND (`jand`), 2-input OR (`jor`) and inverter (`jnot`). It applies them across two WIDTH-bit operand buses. Each function is provided as a combinational output and as a registered copy. The gate semantics match the single-bit primitives used throughout the clock/stepper logic, so the bank is a drop-in for wide gating and for checking primitive behaviour at the bus level.

## Interface
- `WIDTH`, default 8: bit width of operand and result buses; legal range is 1 to 64.
- `clk`, input, 1: single clock; all registers update on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset. It is asserted when 0 and acts immediately, independent of `clk`.
- `en`, input, 1: when 1 at a rising edge, the registered outputs load the current gate results.
- `a`, input, WIDTH: operand A; it is the only input to the inverter.
- `b`, input, WIDTH: operand B.
- `and_o`, output, WIDTH: combinational `a & b`, per bit.
- `or_o`, output, WIDTH: combinational `a | b`, per bit.
- `not_o`, output, WIDTH: combinational `~a`, per bit.
- `and_q`, output, WIDTH: registered AND result.
- `or_q`, output, WIDTH: registered OR result.
- `not_q`, output, WIDTH: registered NOT result.
- `valid_q`, output, 1: 1 once at least one load has occurred since reset.

## Operation
- Each bit position is an independent instance of the primitive, with no cross-bit interaction.
- `jand` semantics: out = in1 AND in2. Output is the last port; argument order is (in1, in2, out).
- `jor` semantics: out = in1 OR in2, with the same port order.
- `jnot` semantics: out = NOT in. Port order is (in, out).
- Combinational outputs:
  - Pure continuous logic with zero delay, no state and no dependence on `clk`, `reset` or `en`.
  - They must stay safe inside feedback/latch structures: no added delay, no internal latches.
- Registered outputs:
  - On a rising `clk` edge with `reset`=1 and `en`=1: `and_q`/`or_q`/`not_q` take `and_o`/`or_o`/`not_o`, and `valid_q` becomes 1.
  - With `en`=0, all registers hold.
- Reset (`reset`=0):
  - `and_q`=0, `or_q`=0, `not_q`=0 and `valid_q`=0, applied immediately.
  - These values are held while `reset` is low, whatever `clk` and `en` do.
- X/Z on inputs propagates per standard Verilog operator rules. No sanitising is done.

## Timing
- Combinational path latency: 0 cycles, with the same-delta response to `a`/`b` changes.
- Registered path latency: 1 cycle. Values sampled at edge N appear after edge N.
- Reset assertion is asynchronous: outputs clear without waiting for a clock edge.
- Reset release takes effect at the first rising edge where `reset`=1. A load occurs there only if `en`=1.
- If `reset` falls in the same timestep as a rising `clk` edge, reset wins and the registers clear.
- Reset mid-operation discards held values. `valid_q` returns to 0 until the next enabled edge.
- No handshake: `en` is a plain load enable and may toggle every cycle.

## Test plan
- Truth table, WIDTH=1: sweep a,b over 00/01/10/11.
  - `and_o` must read 0,0,0,1.
  - `or_o` must read 0,1,1,1.
  - `not_o` must read 1,1,0,0.
- Bus check, WIDTH=8: a=8'hF0, b=8'h3C, en=1, one clock.
  - After the edge: `and_q`=8'h30, `or_q`=8'hFC, `not_q`=8'h0F, `valid_q`=1.
- Enable hold: load a=8'hAA, b=8'h55, then en=0 and change to a=8'h00, b=8'hFF for 3 clocks.
  - `and_q`=8'h00, `or_q`=8'hFF and `not_q`=8'h55 are held throughout.
  - `or_o` tracks 8'hFF immediately.
- Async reset: with the registers loaded, drive `reset`=0 between clock edges.
  - All `_q` outputs and `valid_q` go to 0 before the next edge.
  - Combinational outputs are unaffected.
- Reset release: raise `reset` with en=0 for 2 clocks, then en=1 with a=8'h81, b=8'h01.
  - Outputs stay 0 until the enabled edge.
  - Then `and_q`=8'h01, `or_q`=8'h81, `not_q`=8'h7E.
- Zero-delay check: toggle `a` bit 0 with b=all-ones.
  - `and_o[0]` equals `a[0]` in the same timestep, with no #delay observed.
